// File: rtl/video_timing_fetch.sv
// Programmable HDMI/DVI raster timing with scaled RGB565 framebuffer fetch and sync/DE delay matching.
// Optional macro VIDEO_TEST_PATTERN_EN adds test_pat_i and an 8-bar colour pattern generator.
module video_timing_fetch #(
  parameter int H_ACTIVE    = 1280,
  parameter int H_FP        = 110,
  parameter int H_SYNC      = 40,
  parameter int H_BP        = 220,
  parameter int V_ACTIVE    = 720,
  parameter int V_FP        = 5,
  parameter int V_SYNC      = 5,
  parameter int V_BP        = 20,
  parameter int HS_POL      = 1,
  parameter int VS_POL      = 1,
  parameter int SCALE_SHIFT = 3,
  parameter int MEM_LAT     = 1,
  parameter int AW          = 15,
  parameter int CW          = 12
) (
  input  logic          sys_clk_i,
  input  logic          rst_i,
  input  logic          en_i,
`ifdef VIDEO_TEST_PATTERN_EN
  input  logic          test_pat_i,
`endif
  output logic [AW-1:0] fb_addr_o,
  input  logic [15:0]   fb_rdata_i,
  output logic          vid_hs_o,
  output logic          vid_vs_o,
  output logic          vid_de_o,
  output logic [23:0]   vid_rgb_o,
  output logic [CW-1:0] pix_x_o,
  output logic [CW-1:0] pix_y_o,
  output logic          frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_W    = H_ACTIVE >> SCALE_SHIFT;
  localparam int FB_H    = V_ACTIVE >> SCALE_SHIFT;
  localparam int STG     = MEM_LAT + 1;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] ROW_MASK = CW'((1 << SCALE_SHIFT) - 1);
  localparam logic [AW-1:0] FB_W_C   = AW'(FB_W);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  if ((H_ACTIVE % (1 << SCALE_SHIFT)) != 0 || (V_ACTIVE % (1 << SCALE_SHIFT)) != 0) begin : g_bad_scale
    $error("H_ACTIVE and V_ACTIVE must be multiples of 2**SCALE_SHIFT");
  end
  if (longint'(FB_W) * longint'(FB_H) > (longint'(1) << AW)) begin : g_bad_aw
    $error("scaled framebuffer does not fit in AW address bits");
  end
  if (MEM_LAT < 1 || MEM_LAT > 3) begin : g_bad_lat
    $error("MEM_LAT must be 1..3");
  end
  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
    $error("CW too narrow for raster totals");
  end

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } ctl_t;

  localparam ctl_t CTL_BLANK = '{de: 1'b0, hs: ~HS_ON, vs: ~VS_ON};

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [AW-1:0] rb_q, rb_d, addr_q, addr_d;
  logic          de_nxt;
  logic          de_raw, hs_raw, vs_raw;
  ctl_t          ctl_q [STG:1];
  logic [23:0]   rgb_q, rgb_d;

  // Next-state counters and row base; the fetch address is derived from the
  // next state so fb_addr_o lines up with the counters it belongs to.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    rb_d = rb_q;
    if (!en_i) begin
      h_d = '0;
      v_d = '0;
      rb_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d = '0;
        rb_d = '0;
      end else begin
        v_d = v_q + CW'(1);
        if ((v_d & ROW_MASK) == '0) rb_d = rb_q + FB_W_C;
      end
    end else begin
      h_d = h_q + CW'(1);
    end
    addr_d = rb_d + AW'(h_d >> SCALE_SHIFT);
    de_nxt = (h_d < H_ACT_C) && (v_d < V_ACT_C);
  end

  assign de_raw = en_i && (h_q < H_ACT_C) && (v_q < V_ACT_C);
  assign hs_raw = (en_i && h_q >= HS_BEG && h_q < HS_END) ? HS_ON : ~HS_ON;
  assign vs_raw = (en_i && v_q >= VS_BEG && v_q < VS_END) ? VS_ON : ~VS_ON;

`ifdef VIDEO_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  if (BAR_W < 1) begin : g_bad_bar
    $error("H_ACTIVE must be at least 8 for the test pattern");
  end

  logic [2:0] bar;
  logic [3:0] pat_q [MEM_LAT:1];

  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++)
      if (h_q >= CW'(k * BAR_W)) bar = 3'(k);
  end

  // {pattern active, bar index} rides alongside DE so bars stay aligned.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      for (int k = 1; k <= MEM_LAT; k++) pat_q[k] <= '0;
    end else begin
      pat_q[1] <= {de_raw && test_pat_i, bar};
      for (int k = 2; k <= MEM_LAT; k++) pat_q[k] <= pat_q[k-1];
    end
  end

  // Bar order white..black maps to R=~b[1], G=~b[2], B=~b[0].
  always_comb begin
    rgb_d = ctl_q[MEM_LAT].de ? rgb565_to_888(fb_rdata_i) : 24'h0;
    if (pat_q[MEM_LAT][3])
      rgb_d = {{8{~pat_q[MEM_LAT][1]}}, {8{~pat_q[MEM_LAT][2]}}, {8{~pat_q[MEM_LAT][0]}}};
  end
`else
  always_comb begin
    rgb_d = ctl_q[MEM_LAT].de ? rgb565_to_888(fb_rdata_i) : 24'h0;
  end
`endif

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      h_q    <= '0;
      v_q    <= '0;
      rb_q   <= '0;
      addr_q <= '0;
      rgb_q  <= '0;
      for (int k = 1; k <= STG; k++) ctl_q[k] <= CTL_BLANK;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      rb_q <= rb_d;
      if (de_nxt) addr_q <= addr_d;
      ctl_q[1] <= '{de: de_raw, hs: hs_raw, vs: vs_raw};
      for (int k = 2; k <= STG; k++) ctl_q[k] <= ctl_q[k-1];
      // Read data for the pixel in stage MEM_LAT is on fb_rdata_i now.
      rgb_q <= rgb_d;
    end
  end

  assign fb_addr_o     = addr_q;
  assign vid_de_o      = ctl_q[STG].de;
  assign vid_hs_o      = ctl_q[STG].hs;
  assign vid_vs_o      = ctl_q[STG].vs;
  assign vid_rgb_o     = rgb_q;
  assign pix_x_o       = h_q;
  assign pix_y_o       = v_q;
  assign frame_start_o = !rst_i && en_i && (h_q == '0) && (v_q == '0);

endmodule

// File: tb/tb_video_timing_fetch.sv
// Directed bench for video_timing_fetch on a 14x7 raster (8x4 active, 2x upscale, MEM_LAT=1).
module tb_video_timing_fetch;
  localparam int AW = 8;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b1;
  logic          frc = 1'b0;
  logic [AW-1:0] fb_addr;
  logic [15:0]   fb_rdata = 16'h0;
  logic          vid_hs, vid_vs, vid_de, fs;
  logic [23:0]   vid_rgb;
  logic [CW-1:0] pix_x, pix_y;
`ifdef VIDEO_TEST_PATTERN_EN
  logic          tp = 1'b0;
  logic [23:0]   pat_e [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

  int npass = 0;
  int ntot  = 0;
  int hsc = 0, vsc = 0, dec = 0, fsc = 0, fs_last = -1, fs_per = 0;
  logic found;
  logic [7:0] tbl [4][8] = '{'{0, 0, 1, 1, 2, 2, 3, 3}, '{0, 0, 1, 1, 2, 2, 3, 3},
                            '{4, 4, 5, 5, 6, 6, 7, 7}, '{4, 4, 5, 5, 6, 6, 7, 7}};

  video_timing_fetch #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .SCALE_SHIFT(1), .MEM_LAT(1), .AW(AW), .CW(CW)
  ) dut (
    .sys_clk_i(clk),
    .rst_i(rst),
    .en_i(en),
`ifdef VIDEO_TEST_PATTERN_EN
    .test_pat_i(tp),
`endif
    .fb_addr_o(fb_addr),
    .fb_rdata_i(fb_rdata),
    .vid_hs_o(vid_hs),
    .vid_vs_o(vid_vs),
    .vid_de_o(vid_de),
    .vid_rgb_o(vid_rgb),
    .pix_x_o(pix_x),
    .pix_y_o(pix_y),
    .frame_start_o(fs)
  );

  always #5 clk = ~clk;

  // One-cycle framebuffer: returns its own address unless forced to magenta.
  always @(posedge clk) fb_rdata <= frc ? 16'hF81F : 16'(fb_addr);

  function automatic logic [23:0] f565(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_hs", vid_hs, 0);
    chk("rst_vs", vid_vs, 0);
    chk("rst_de", vid_de, 0);
    chk("rst_rgb", vid_rgb, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_fs", fs, 0);
    chk("rst_x", pix_x, 0);
    chk("rst_y", pix_y, 0);

    // Two full frames against the reference raster.
    rst = 1'b0;
    for (int k = 0; k < 198; k++) begin
      int h, v, h2, v2;
      logic de_e, hs_e, vs_e;
      logic [23:0] rgb_e;
      #1;
      h = k % 14;
      v = (k / 14) % 7;
      chk("pix_x", pix_x, h);
      chk("pix_y", pix_y, v);
      chk("frame_start", fs, (h == 0 && v == 0));
      if (h < 8 && v < 4) chk("fb_addr", fb_addr, tbl[v][h]);
      de_e = 1'b0; hs_e = 1'b0; vs_e = 1'b0; rgb_e = 24'h0;
      if (k >= 2) begin
        h2 = (k - 2) % 14;
        v2 = ((k - 2) / 14) % 7;
        de_e = (h2 < 8 && v2 < 4);
        hs_e = (h2 >= 10 && h2 < 12);
        vs_e = (v2 == 5);
        if (de_e) rgb_e = f565(16'(tbl[v2][h2]));
        hsc += int'(vid_hs);
        vsc += int'(vid_vs);
        dec += int'(vid_de);
      end
      chk("de", vid_de, de_e);
      chk("hs", vid_hs, hs_e);
      chk("vs", vid_vs, vs_e);
      chk("rgb", vid_rgb, rgb_e);
      if (fs && k < 196) begin
        fsc++;
        if (fs_last >= 0) fs_per = k - fs_last;
        fs_last = k;
      end
      @(negedge clk);
    end
    chk("hs_count", hsc, 28);
    chk("vs_count", vsc, 28);
    chk("de_count", dec, 64);
    chk("fs_count", fsc, 2);
    chk("fs_period", fs_per, 98);

    // Expansion of a forced magenta word, and zero during blanking.
    frc = 1'b1;
    repeat (3) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) if (vid_de) found = 1'b1; else @(negedge clk);
    chk("exp_wait_de", found, 1);
    chk("exp_rgb", vid_rgb, 24'hFF00FF);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) if (!vid_de) found = 1'b1; else @(negedge clk);
    chk("exp_wait_blank", found, 1);
    chk("blank_rgb", vid_rgb, 0);
    frc = 1'b0;

    // Drop enable at (5,2).
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++)
      if (pix_x == 5 && pix_y == 2) found = 1'b1; else @(negedge clk);
    chk("en_wait", found, 1);
    en = 1'b0;
    @(negedge clk);
    chk("en0_x", pix_x, 0);
    chk("en0_y", pix_y, 0);
    chk("en0_de_t1", vid_de, 1);
    @(negedge clk);
    chk("en0_de_t2", vid_de, 0);
    chk("en0_fs", fs, 0);
    @(negedge clk);
    chk("en0_hold_x", pix_x, 0);
    chk("en0_hold_hs", vid_hs, 0);
    en = 1'b1;
    #1;
    chk("en1_fs", fs, 1);
    @(negedge clk);
    chk("en1_x", pix_x, 1);
    chk("en1_fs_off", fs, 0);
    repeat (3) @(negedge clk);
    chk("mid_x", pix_x, 4);
    chk("mid_de", vid_de, 1);
    chk("mid_rgb", vid_rgb, 24'h000008);

    // Reset in the middle of an active line.
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_x", pix_x, 0);
    chk("mrst_y", pix_y, 0);
    chk("mrst_addr", fb_addr, 0);
    chk("mrst_de", vid_de, 0);
    chk("mrst_rgb", vid_rgb, 0);
    chk("mrst_hs", vid_hs, 0);
    chk("mrst_vs", vid_vs, 0);
    chk("mrst_fs", fs, 0);

`ifdef VIDEO_TEST_PATTERN_EN
    tp  = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk("pat_de", vid_de, 1);
      chk("pat_rgb", vid_rgb, pat_e[i]);
      @(negedge clk);
    end
    chk("pat_blank", vid_rgb, 0);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
